// File: rtl/arbiter_pkg.sv
// Types and constants for the RAM round-robin arbiter.
package arbiter_pkg;
  typedef enum logic {IDLE, SERVE} arb_state_t;
  localparam logic [31:0] ARB_ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of cand scanning ptr, ptr+1, ... mod NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         cand,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] j;

  // Scan from the farthest offset down so the offset nearest ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    j     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = ptr + PW'(i);
      if (cand[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one RAM port among NREQ requesters with write-first round-robin
// selection, holds each grant until ACCESS, and force-releases hung grants.
module ram_rr_arbiter
  import cpu_types_pkg::*;
  import arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WRITE_FIRST = 1,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_ren,
  input  logic [NREQ-1:0]         req_wen,
  input  word_t [NREQ-1:0]        req_addr,
  input  word_t [NREQ-1:0]        req_store,
  output logic [NREQ-1:0]         req_wait,
  output word_t [NREQ-1:0]        req_load,
  output logic                    ramREN,
  output logic                    ramWEN,
  output word_t                   ramaddr,
  output word_t                   ramstore,
  input  word_t                   ramload,
  input  ramstate_t               ramstate,
  output logic                    timeout_err,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int PW      = $clog2(NREQ);
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  arb_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] cand;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            g_ren, g_wen, to_hit;

  // Candidate set: pending writes only when write-first applies, else all requests.
  always_comb begin
    if ((WRITE_FIRST != 0) && (|req_wen)) cand = req_wen;
    else                                  cand = req_ren | req_wen;
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign grant_id = grant_q;

  // Control registers; async reset also kills RAM enables via state_q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and RAM/requester outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    req_wait    = '1;
    req_load    = {NREQ{ramload}};
    timeout_err = 1'b0;
    g_ren       = req_ren[grant_q];
    g_wen       = req_wen[grant_q];
    to_hit      = (TIMEOUT != 0) && (cnt_q == TO_W'(TO_LAST));
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        ramREN   = g_ren & ~g_wen;
        ramWEN   = g_wen;
        ramaddr  = req_addr[grant_q];
        ramstore = req_store[grant_q];
        if (!g_ren && !g_wen) begin
          // Requester withdrew: release without touching ptr or wait bits.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (ramstate == ACCESS) begin
          req_wait[grant_q] = 1'b0;
          state_d = IDLE;
          ptr_d   = grant_q + PW'(1);
          cnt_d   = '0;
        end else if (to_hit) begin
          req_wait[grant_q] = 1'b0;
          req_load[grant_q] = ARB_ERR_WORD;
          timeout_err       = 1'b1;
          state_d = IDLE;
          ptr_d   = grant_q + PW'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter (NREQ=4, WRITE_FIRST=1, TIMEOUT=4).
module tb_ram_rr_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic [3:0]  req_ren, req_wen, req_wait;
  word_t [3:0] req_addr, req_store, req_load;
  logic        ramREN, ramWEN, timeout_err;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate, ram_forced;
  logic        ram_auto;
  logic [1:0]  grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  ram_rr_arbiter #(.NREQ(4), .WRITE_FIRST(1), .TIMEOUT(4), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .timeout_err(timeout_err), .grant_id(grant_id)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: either answers ACCESS to any enabled cycle, or holds a forced state.
  always_comb begin
    if (ram_auto && (ramREN || ramWEN)) ramstate = ACCESS;
    else                                 ramstate = ram_forced;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; req_ren = '0; req_wen = '0; ramload = 32'h0;
    ram_auto = 1'b0; ram_forced = FREE;
    for (int i = 0; i < 4; i++) begin
      req_addr[i]  = 32'hA000_0000 + 32'(i);
      req_store[i] = 32'h5000_0000 + 32'(i);
    end
    #3;
    chk("rst_wait", 32'(req_wait), 32'hF);
    chk("rst_en", {30'b0, ramREN, ramWEN}, 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    #9 RST = 1'b0;
    tick();

    // All four reading, RAM answers at once: grants 0,1,2,3,0 every 2 cycles.
    ram_auto = 1'b1;
    req_ren  = 4'hF;
    #1 chk("rr_idle0_wait", 32'(req_wait), 32'hF);
    for (int k = 0; k < 5; k++) begin
      ramload = 32'h1000 + 32'(k);
      tick();
      chk("rr_gid", 32'(grant_id), 32'(k % 4));
      chk("rr_ren", 32'(ramREN), 32'h1);
      chk("rr_wait_low", 32'(req_wait), 32'(~(4'b1 << (k % 4)) & 4'hF));
      chk("rr_load", req_load[k % 4], 32'h1000 + 32'(k));
      tick();
      chk("rr_idle_wait", 32'(req_wait), 32'hF);
      chk("rr_idle_ren", 32'(ramREN), 32'h0);
    end
    req_ren  = '0;
    ram_auto = 1'b0;
    tick();

    // Async reset during a write; ptr (was 1) must return to 0.
    req_wen = 4'b0100;
    tick();
    chk("rs_wen_on", 32'(ramWEN), 32'h1);
    chk("rs_gid", 32'(grant_id), 32'h2);
    chk("rs_addr", ramaddr, 32'hA000_0002);
    #2 RST = 1'b1;
    #1;
    chk("rs_wen_async", 32'(ramWEN), 32'h0);
    chk("rs_wait", 32'(req_wait), 32'hF);
    chk("rs_gid0", 32'(grant_id), 32'h0);
    req_wen = '0;
    req_ren = 4'b1011;
    #1 RST = 1'b0;
    tick();
    chk("rs_ptr0_gid", 32'(grant_id), 32'h0);
    ram_forced = ACCESS;
    #1 chk("rs_done_wait", 32'(req_wait), 32'hE);
    tick();
    ram_forced = FREE;
    req_ren = 4'b1000;
    tick();
    chk("pre3_gid", 32'(grant_id), 32'h3);
    ram_forced = ACCESS;
    tick();
    ram_forced = FREE;

    // Write-first with ptr=0: reader 0 and writer 3 -> 3 first, then 0.
    req_ren = 4'b0001;
    req_wen = 4'b1000;
    tick();
    chk("wf_gid", 32'(grant_id), 32'h3);
    chk("wf_wen", {30'b0, ramREN, ramWEN}, 32'h1);
    chk("wf_store", ramstore, 32'h5000_0003);
    ram_forced = ACCESS;
    #1 chk("wf_wait", 32'(req_wait), 32'h7);
    tick();
    ram_forced = FREE;
    req_wen = '0;
    tick();
    chk("wf_next_gid", 32'(grant_id), 32'h0);
    chk("wf_next_ren", 32'(ramREN), 32'h1);
    ram_forced = ACCESS;
    tick();
    ram_forced = FREE;
    req_ren = '0;

    // Timeout: requester 2 granted with RAM stuck BUSY (ptr=1 now).
    req_ren = 4'b0100;
    ramload = 32'h7777_7777;
    tick();
    chk("to_gid", 32'(grant_id), 32'h2);
    ram_forced = BUSY;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c < 4) begin
        chk("to_wait_hold", 32'(req_wait), 32'hF);
        chk("to_err_low", 32'(timeout_err), 32'h0);
      end else begin
        chk("to_wait_rel", 32'(req_wait), 32'hB);
        chk("to_load_err", req_load[2], 32'hBAD1BAD1);
        chk("to_load_other", req_load[0], 32'h7777_7777);
        chk("to_err_pulse", 32'(timeout_err), 32'h1);
      end
      tick();
    end
    ram_forced = FREE;
    chk("to_err_after", 32'(timeout_err), 32'h0);
    req_ren = 4'b1101;
    tick();
    chk("to_next_gid", 32'(grant_id), 32'h3);
    ram_forced = ACCESS;
    tick();
    ram_forced = FREE;
    req_ren = '0;

    // Abort: requester 1 drops its read before ACCESS (ptr=0).
    req_ren = 4'b0010;
    tick();
    chk("ab_gid", 32'(grant_id), 32'h1);
    chk("ab_ren_on", 32'(ramREN), 32'h1);
    req_ren = '0;
    #1;
    chk("ab_ren_off", 32'(ramREN), 32'h0);
    chk("ab_wait", 32'(req_wait), 32'hF);
    tick();
    chk("ab_idle_wait", 32'(req_wait), 32'hF);
    req_ren = 4'b0110;
    tick();
    chk("ab_ptr_kept", 32'(grant_id), 32'h1);
    req_ren = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
